mmm_par_ctrl: RTL and testbench

MMM_PAR_CTRL -- requirements
Module: mmm_par_ctrl

---
 rtl/mmm_pkg.sv | 26 ++
 rtl/ctrl_delay_line.sv | 37 +++
 rtl/mmm_par_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mmm_par_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// ---------------------------------------------------------------------------
// mmm_pkg
// Shared types and width helpers for the parallel matrix-multiply controller.
//   state_t    : controller FSM states
//   bits_for   : address/counter width for n distinct values (never below 1)
//   count_bits : width needed to hold the values 0..max_val inclusive
// ---------------------------------------------------------------------------
package mmm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_STALL   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_bits(input int max_val);
        return bits_for(max_val + 1);
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// ---------------------------------------------------------------------------
// ctrl_delay_line
// Fixed-latency shift register for control strobes; DEPTH >= 1 cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears every stage
//   din   : WIDTH-bit strobe vector entering the line
//   dout  : din delayed by exactly DEPTH cycles
// ---------------------------------------------------------------------------
module ctrl_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/mmm_par_ctrl.sv
// ---------------------------------------------------------------------------
// mmm_par_ctrl
// Sequencer for a P-lane matrix multiply C[M x N] = A[M x K] * B[K x N].
// Walks (r, c, k) with k innermost, issuing one A/B read per cycle, and
// throttles the last term of each column group against free FIFO space.
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset
//   matrices_loaded  : start request, honoured only in IDLE
//   K                : inner dimension, latched at start
//   fifo_capacity    : free P-wide entries in the result FIFO
//   a_addr, b_addr   : A read address, shared B-bank read address
//   mac_valid        : read data valid at the MAC lanes
//   mac_clear        : restart accumulation (first term of a group)
//   fifo_wr_en       : push one finished result group
//   compute_finished : one-cycle completion pulse
//   k_err            : K was outside 1..MAXK (high with compute_finished)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for matrices_loaded; K latched on start
// COMPUTE  | issuing one term per cycle
// STALL    | last term of a group held back, FIFO space exhausted
// DRAIN    | all terms issued, waiting for outstanding groups to be written
// DONE     | one-cycle completion pulse
// ---------------------------------------------------------------------------
module mmm_par_ctrl
    import mmm_pkg::*;
#(
    parameter int M       = 7,
    parameter int N       = 8,
    parameter int MAXK    = 8,
    parameter int P       = 2,
    parameter int MAC_LAT = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 matrices_loaded,
    input  logic [count_bits(MAXK)-1:0]          K,
    input  logic [count_bits(N/P)-1:0]           fifo_capacity,
    output logic [bits_for(M*MAXK)-1:0]          a_addr,
    output logic [bits_for(MAXK*(N/P))-1:0]      b_addr,
    output logic                                 mac_valid,
    output logic                                 mac_clear,
    output logic                                 fifo_wr_en,
    output logic                                 compute_finished,
    output logic                                 k_err
);

    localparam int G     = N / P;
    localparam int A_W   = bits_for(M * MAXK);
    localparam int B_W   = bits_for(MAXK * G);
    localparam int K_W   = count_bits(MAXK);
    localparam int CAP_W = count_bits(G);
    localparam int R_W   = bits_for(M);
    localparam int C_W   = bits_for(G);

    localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
    localparam logic [K_W-1:0]   MAXK_V  = K_W'(MAXK);
    localparam logic [R_W-1:0]   R_ONE   = R_W'(1);
    localparam logic [R_W-1:0]   R_LAST  = R_W'(M - 1);
    localparam logic [C_W-1:0]   C_ONE   = C_W'(1);
    localparam logic [C_W-1:0]   C_LAST  = C_W'(G - 1);
    localparam logic [CAP_W-1:0] CAP_ONE = CAP_W'(1);

    state_t             state, state_nx;
    logic [R_W-1:0]     r_cnt, r_nx;
    logic [C_W-1:0]     c_cnt, c_nx;
    logic [K_W-1:0]     k_cnt, k_nx;
    logic [K_W-1:0]     k_lat, k_lat_nx;
    logic [CAP_W-1:0]   inflight, inflight_now, inflight_nx;
    logic               k_err_nx;
    logic               k_legal;
    logic               term_last;
    logic               term_final;
    logic               room;
    logic               issue;
    logic [1:0]         mac_ctl;

    assign k_legal    = (K != '0) && (K <= MAXK_V);
    assign term_last  = (k_cnt == k_lat - K_ONE);
    assign term_final = term_last && (c_cnt == C_LAST) && (r_cnt == R_LAST);

    // A group retiring this cycle frees its slot for a last term issued in
    // the same cycle, so the capacity test uses the post-retire count.
    assign inflight_now = fifo_wr_en ? inflight - CAP_ONE : inflight;
    assign room         = inflight_now < fifo_capacity;
    assign inflight_nx  = (issue && term_last) ? inflight_now + CAP_ONE : inflight_now;

    assign a_addr = A_W'(r_cnt) * A_W'(k_lat) + A_W'(k_cnt);
    assign b_addr = B_W'(k_cnt) * B_W'(G) + B_W'(c_cnt);

    assign compute_finished = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            r_cnt    <= '0;
            c_cnt    <= '0;
            k_cnt    <= '0;
            k_lat    <= '0;
            inflight <= '0;
            k_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            r_cnt    <= r_nx;
            c_cnt    <= c_nx;
            k_cnt    <= k_nx;
            k_lat    <= k_lat_nx;
            inflight <= inflight_nx;
            k_err    <= k_err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        r_nx     = r_cnt;
        c_nx     = c_cnt;
        k_nx     = k_cnt;
        k_lat_nx = k_lat;
        k_err_nx = 1'b0;
        issue    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (matrices_loaded) begin
                    k_lat_nx = K;
                    r_nx     = '0;
                    c_nx     = '0;
                    k_nx     = '0;
                    if (k_legal) begin
                        state_nx = ST_COMPUTE;
                    end else begin
                        k_err_nx = 1'b1;
                        state_nx = ST_DONE;
                    end
                end
            end

            // STALL re-evaluates the same issue test every cycle, so the
            // held term goes out on the first cycle space is available.
            ST_COMPUTE, ST_STALL: begin
                issue = !term_last || room;
                if (issue) begin
                    if (term_last) begin
                        k_nx = '0;
                        if (c_cnt == C_LAST) begin
                            c_nx = '0;
                            r_nx = (r_cnt == R_LAST) ? '0 : r_cnt + R_ONE;
                        end else begin
                            c_nx = c_cnt + C_ONE;
                        end
                    end else begin
                        k_nx = k_cnt + K_ONE;
                    end
                    state_nx = term_final ? ST_DRAIN : ST_COMPUTE;
                end else begin
                    state_nx = ST_STALL;
                end
            end

            ST_DRAIN: begin
                if (inflight_now == '0) begin
                    state_nx = ST_DONE;
                end
            end

            ST_DONE: begin
                r_nx     = '0;
                c_nx     = '0;
                k_nx     = '0;
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    ctrl_delay_line #(
        .WIDTH (2),
        .DEPTH (1)
    ) u_mac_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({issue, issue && (k_cnt == '0)}),
        .dout  (mac_ctl)
    );

    assign mac_valid = mac_ctl[1];
    assign mac_clear = mac_ctl[0];

    ctrl_delay_line #(
        .WIDTH (1),
        .DEPTH (1 + MAC_LAT)
    ) u_wr_dly (
        .clk   (clk),
        .reset (reset),
        .din   (issue && term_last),
        .dout  (fifo_wr_en)
    );

endmodule

// File: tb/tb_mmm_par_ctrl.sv
module tb_mmm_par_ctrl;

    localparam int M       = 2;
    localparam int N       = 4;
    localparam int P       = 2;
    localparam int MAXK    = 4;
    localparam int MAC_LAT = 3;
    localparam int G       = N / P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       matrices_loaded = 1'b0;
    logic [2:0] K = '0;
    logic [1:0] fifo_capacity = 2'd2;
    logic [2:0] a_addr;
    logic [2:0] b_addr;
    logic       mac_valid;
    logic       mac_clear;
    logic       fifo_wr_en;
    logic       compute_finished;
    logic       k_err;

    always #5 clk = ~clk;

    mmm_par_ctrl #(
        .M       (M),
        .N       (N),
        .MAXK    (MAXK),
        .P       (P),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (matrices_loaded),
        .K                (K),
        .fifo_capacity    (fifo_capacity),
        .a_addr           (a_addr),
        .b_addr           (b_addr),
        .mac_valid        (mac_valid),
        .mac_clear        (mac_clear),
        .fifo_wr_en       (fifo_wr_en),
        .compute_finished (compute_finished),
        .k_err            (k_err)
    );

    typedef struct {
        int a;
        int b;
        bit clr;
        bit last;
    } term_t;

    term_t exp_q[$];
    int    wr_due[$];
    term_t mon_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int outstanding = 0;
    int done_cnt    = 0;
    int prev_a      = 0;
    int prev_b      = 0;
    bit prev_may    = 1'b0;
    bit running     = 1'b0;
    bit expect_kerr = 1'b0;
    bit mon_en      = 1'b0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compares what the DUT presents against the reference model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fifo_wr_en) begin
                if (wr_due.size() == 0) begin
                    check("unexpected fifo_wr_en", 1, 0);
                end else begin
                    check("fifo_wr_en cycle", cyc, wr_due.pop_front());
                    outstanding--;
                end
            end

            check("mac_valid schedule", int'(mac_valid), int'(prev_may));

            if (mac_valid) begin
                if (exp_q.size() == 0) begin
                    check("mac_valid without work", 1, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check("a_addr", prev_a, mon_t.a);
                    check("b_addr", prev_b, mon_t.b);
                    check("mac_clear", int'(mac_clear), int'(mon_t.clr));
                    if (mon_t.last) begin
                        wr_due.push_back(cyc + MAC_LAT);
                        outstanding++;
                    end
                end
            end else if (mac_clear) begin
                check("mac_clear without mac_valid", 1, 0);
            end

            if (compute_finished) begin
                check("compute_finished while idle", int'(running), 1);
                check("compute_finished with work pending", exp_q.size() + wr_due.size(), 0);
                check("k_err with done", int'(k_err), int'(expect_kerr));
                done_cnt++;
                running = 1'b0;
            end else begin
                check("k_err outside done", int'(k_err), 0);
            end

            // Next term may issue this cycle unless it closes a group and
            // the FIFO has no room beyond the groups still outstanding.
            if (running && exp_q.size() > 0)
                prev_may = !exp_q[0].last || (outstanding < int'(fifo_capacity));
            else
                prev_may = 1'b0;
            prev_a = int'(a_addr);
            prev_b = int'(b_addr);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " a_addr"}, int'(a_addr), 0);
        check({tag, " b_addr"}, int'(b_addr), 0);
        check({tag, " mac_valid"}, int'(mac_valid), 0);
        check({tag, " mac_clear"}, int'(mac_clear), 0);
        check({tag, " fifo_wr_en"}, int'(fifo_wr_en), 0);
        check({tag, " compute_finished"}, int'(compute_finished), 0);
        check({tag, " k_err"}, int'(k_err), 0);
    endtask

    // mode: 0 cap=2, 1 cap=1, 2 random 0..2, 3 cap=1 then 2, 4 cap=0 then 2
    task automatic run_problem(input int kval, input int mode, input int abort_at);
        bit legal;
        int start_cnt;
        legal = (kval >= 1) && (kval <= MAXK);
        @(posedge clk); #2;
        K = 3'(kval);
        matrices_loaded = 1'b1;
        if (legal) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < G; c++)
                    for (int k = 0; k < kval; k++)
                        exp_q.push_back('{r * kval + k, k * G + c, k == 0, k == kval - 1});
        end
        expect_kerr = !legal;
        start_cnt   = done_cnt;
        @(posedge clk); #2;
        matrices_loaded = 1'b0;
        running = 1'b1;
        K = 3'($urandom_range(0, 7));
        for (int i = 0; i < 400 && done_cnt == start_cnt; i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                exp_q.delete();
                wr_due.delete();
                outstanding = 0;
                running  = 1'b0;
                prev_may = 1'b0;
                #1;
                check_all_zero("mid-run reset");
                repeat (3) @(posedge clk);
                #2;
                reset = 1'b1;
                repeat (12) @(posedge clk);
                #2;
                return;
            end
            case (mode)
                0: fifo_capacity = 2'd2;
                1: fifo_capacity = 2'd1;
                2: fifo_capacity = 2'($urandom_range(0, 2));
                3: fifo_capacity = (i < 8) ? 2'd1 : 2'd2;
                default: fifo_capacity = (i < 10) ? 2'd0 : 2'd2;
            endcase
            @(posedge clk); #2;
        end
        check("compute_finished within budget", done_cnt - start_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset  = 1'b1;
        mon_en = 1'b1;

        run_problem(3, 0, -1);
        run_problem(3, 1, -1);
        run_problem(3, 3, -1);
        run_problem(1, 0, -1);
        run_problem(1, 1, -1);
        run_problem(0, 0, -1);
        run_problem(5, 0, -1);
        run_problem(4, 4, -1);
        run_problem(2, 2, -1);
        run_problem(3, 0, 6);
        run_problem(3, 0, -1);
        for (int n = 0; n < 12; n++) begin
            run_problem(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), -1);
        end
        repeat (4) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
